// File: rtl/lcd_frame_fetch_ctrl.sv
`default_nettype none
// ===========================================================================
// lcd_frame_fetch_ctrl : burst read scheduler filling the LCD pixel FIFO, one
// frame per vsync. Macro LCD_FETCH_DBLBUF_EN adds ping-pong base select. Rev 1.0
// ===========================================================================
module lcd_frame_fetch_ctrl #(
  parameter int ADDR_W     = 24,
  parameter int BURST_LEN  = 64,
  parameter int FIFO_DEPTH = 512,
  parameter int LEVEL_W    = 10
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              ctrl_en,
  input  logic              out_vsync,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic [ADDR_W-1:0] frame_base,
`ifdef LCD_FETCH_DBLBUF_EN
  input  logic [ADDR_W-1:0] frame_base_b,
  input  logic              buf_sel,
  output logic              cur_buf,
`endif
  input  logic [LEVEL_W-1:0] fifo_level,
  output logic              fifo_flush,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              frame_active,
  output logic              frame_done,
  output logic              underrun
);

  localparam int          REM_W       = 22;
  localparam int unsigned LEVEL_LIMIT = FIFO_DEPTH - BURST_LEN;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_CHECK = 3'd2,
    S_REQ   = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         vs_q;
  logic [1:0]         flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [7:0]         rd_len_q, rd_len_d;
  logic [10:0]        h_q, h_d, v_q, v_d;
  logic [REM_W-1:0]   remaining_q, remaining_d;
  logic               pending_q, pending_d;
  logic               fse;
  logic               level_ok;
  logic               latch;
  logic [7:0]         burst_len;
  logic [ADDR_W-1:0]  base_sel;

  assign fse       = vs_q[1] & ~vs_q[2];
  assign level_ok  = 32'(fifo_level) <= LEVEL_LIMIT;
  assign burst_len = (remaining_q < REM_W'(BURST_LEN)) ? remaining_q[7:0] : 8'(BURST_LEN);

`ifdef LCD_FETCH_DBLBUF_EN
  logic cur_buf_q, cur_buf_d;
  assign base_sel = buf_sel ? frame_base_b : frame_base;
  assign cur_buf  = cur_buf_q;
`else
  assign base_sel = frame_base;
`endif

  assign fifo_flush   = (state_q == S_FLUSH);
  assign rd_req       = (state_q == S_REQ);
  assign frame_active = (state_q != S_IDLE);
  assign rd_addr      = rd_addr_q;
  assign rd_len       = rd_len_q;
  // A restart only counts as an underrun if words of the old frame are still owed.
  assign underrun     = fse && (state_q != S_IDLE) && (remaining_q != '0);

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    rd_len_d    = rd_len_q;
    h_d         = h_q;
    v_d         = v_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    frame_done  = 1'b0;
    latch       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fse && ctrl_en) begin
          latch   = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        remaining_d = REM_W'(h_q) * REM_W'(v_q);
        flush_cnt_d = flush_cnt_q + 2'd1;
        if (flush_cnt_q == 2'd3) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (pending_q) begin
          pending_d = 1'b0;
          if (ctrl_en) begin
            latch   = 1'b1;
            state_d = S_FLUSH;
          end else begin
            state_d = S_IDLE;
          end
        end else if (remaining_q == '0) begin
          frame_done = 1'b1;
          state_d    = S_IDLE;
        end else if (!ctrl_en) begin
          state_d = S_IDLE;
        end else if (level_ok) begin
          rd_addr_d = addr_q;
          rd_len_d  = burst_len;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (rd_ack) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rd_done) begin
          addr_d      = addr_q + ADDR_W'(rd_len_q);
          remaining_d = remaining_q - REM_W'(rd_len_q);
          state_d     = S_CHECK;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (latch) begin
      addr_d      = base_sel;
      h_d         = h_disp;
      v_d         = v_disp;
      flush_cnt_d = 2'd0;
    end

    // Set after the CHECK clear so a same-cycle new edge is never lost.
    if (fse && (state_q != S_IDLE)) pending_d = 1'b1;
  end

`ifdef LCD_FETCH_DBLBUF_EN
  always_comb begin
    cur_buf_d = cur_buf_q;
    if (latch) cur_buf_d = buf_sel;
  end
`endif

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      vs_q        <= 3'b000;
      flush_cnt_q <= 2'd0;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      rd_len_q    <= 8'd0;
      h_q         <= 11'd0;
      v_q         <= 11'd0;
      remaining_q <= '0;
      pending_q   <= 1'b0;
`ifdef LCD_FETCH_DBLBUF_EN
      cur_buf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      vs_q        <= {vs_q[1:0], out_vsync};
      flush_cnt_q <= flush_cnt_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_len_q    <= rd_len_d;
      h_q         <= h_d;
      v_q         <= v_d;
      remaining_q <= remaining_d;
      pending_q   <= pending_d;
`ifdef LCD_FETCH_DBLBUF_EN
      cur_buf_q   <= cur_buf_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_fetch_ctrl.sv
`default_nettype none
// Directed bench for lcd_frame_fetch_ctrl: frame table plus backpressure,
// reset, mid-frame vsync and (optional) double-buffer sequences.
`timescale 1ns/1ps
module tb_lcd_frame_fetch_ctrl;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        ctrl_en = 1'b0;
  logic        out_vsync = 1'b0;
  logic [10:0] h_disp = '0;
  logic [10:0] v_disp = '0;
  logic [23:0] frame_base = '0;
  logic [9:0]  fifo_level = '0;
  logic        rd_ack = 1'b0;
  logic        rd_done = 1'b0;
  logic        fifo_flush, rd_req, frame_active, frame_done, underrun;
  logic [23:0] rd_addr;
  logic [7:0]  rd_len;
`ifdef LCD_FETCH_DBLBUF_EN
  logic [23:0] frame_base_b = '0;
  logic        buf_sel = 1'b0;
  logic        cur_buf;
`endif

  lcd_frame_fetch_ctrl dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .ctrl_en      (ctrl_en),
    .out_vsync    (out_vsync),
    .h_disp       (h_disp),
    .v_disp       (v_disp),
    .frame_base   (frame_base),
`ifdef LCD_FETCH_DBLBUF_EN
    .frame_base_b (frame_base_b),
    .buf_sel      (buf_sel),
    .cur_buf      (cur_buf),
`endif
    .fifo_level   (fifo_level),
    .fifo_flush   (fifo_flush),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_ack       (rd_ack),
    .rd_done      (rd_done),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .underrun     (underrun)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [23:0] base;
    int          nb;
    logic [23:0] first_addr;
    logic [7:0]  first_len;
    logic [23:0] last_addr;
    logic [7:0]  last_len;
  } vec_t;

  vec_t tbl[9];

  int          nb, nf, nd, nu;
  logic [23:0] first_addr, last_addr;
  logic [7:0]  first_len, last_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_req"}, 32'(rd_req), 0);
    check({tag, "_rd_addr"}, 32'(rd_addr), 0);
    check({tag, "_rd_len"}, 32'(rd_len), 0);
    check({tag, "_flush"}, 32'(fifo_flush), 0);
    check({tag, "_active"}, 32'(frame_active), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_underrun"}, 32'(underrun), 0);
  endtask

  // Full frame with an arbiter that acks and completes one cycle after each step.
  task automatic run_frame(input logic [10:0] h, input logic [10:0] v, input logic [23:0] base);
    int   phase;
    logic got_done;
    logic [23:0] exp_addr;
    h_disp = h; v_disp = v; frame_base = base; ctrl_en = 1'b1; out_vsync = 1'b1;
    nb = 0; nf = 0; nd = 0; nu = 0; phase = 0; got_done = 1'b0;
    for (int c = 0; c < 3000 && !got_done; c++) begin
      tick();
      if (c == 3) out_vsync = 1'b0;
      if (fifo_flush) nf++;
      if (underrun) nu++;
      if (frame_done) begin nd++; got_done = 1'b1; end
      case (phase)
        0: if (rd_req) begin
          if (nb == 0) begin
            first_addr = rd_addr; first_len = rd_len;
          end else begin
            exp_addr = last_addr + 24'(last_len);
            check("burst_contiguous", 32'(rd_addr), 32'(exp_addr));
          end
          last_addr = rd_addr; last_len = rd_len;
          nb++; rd_ack = 1'b1; phase = 1;
        end
        1: begin rd_ack = 1'b0; rd_done = 1'b1; phase = 2; end
        default: begin rd_done = 1'b0; phase = 0; end
      endcase
    end
    out_vsync = 1'b0; rd_ack = 1'b0; rd_done = 1'b0;
    check("frame_done_seen", 32'(got_done), 1);
    repeat (3) begin
      tick();
      if (frame_done) nd++;
    end
    check("idle_after_frame", 32'(frame_active), 0);
  endtask

  task automatic wait_req(input int max, output logic ok);
    for (int c = 0; c < max && !rd_req; c++) tick();
    ok = rd_req;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    int   cnt;

    tbl[0] = '{11'd8,   11'd20, 24'h000100, 3, 24'h000100, 8'd64, 24'h000180, 8'd32};
    tbl[1] = '{11'd8,   11'd0,  24'h001000, 0, 24'h0,      8'd0,  24'h0,      8'd0};
    tbl[2] = '{11'd0,   11'd5,  24'h002000, 0, 24'h0,      8'd0,  24'h0,      8'd0};
    tbl[3] = '{11'd16,  11'd8,  24'hFFFFE0, 2, 24'hFFFFE0, 8'd64, 24'h000020, 8'd64};
    tbl[4] = '{11'd3,   11'd7,  24'h123456, 1, 24'h123456, 8'd21, 24'h123456, 8'd21};
    tbl[5] = '{11'd100, 11'd1,  24'h000000, 2, 24'h000000, 8'd64, 24'h000040, 8'd36};
    tbl[6] = '{11'd64,  11'd1,  24'h000055, 1, 24'h000055, 8'd64, 24'h000055, 8'd64};
    tbl[7] = '{11'd1,   11'd1,  24'hFFFFFF, 1, 24'hFFFFFF, 8'd1,  24'hFFFFFF, 8'd1};
    tbl[8] = '{11'd640, 11'd1,  24'h200000, 10, 24'h200000, 8'd64, 24'h200240, 8'd64};

    repeat (2) tick();
    check_idle_outputs("reset");
    sys_rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 9; i++) begin
      run_frame(tbl[i].h, tbl[i].v, tbl[i].base);
      check($sformatf("v%0d_nbursts", i), 32'(nb), 32'(tbl[i].nb));
      check($sformatf("v%0d_flush_cycles", i), 32'(nf), 4);
      check($sformatf("v%0d_done_pulses", i), 32'(nd), 1);
      check($sformatf("v%0d_underruns", i), 32'(nu), 0);
      if (tbl[i].nb > 0) begin
        check($sformatf("v%0d_first_addr", i), 32'(first_addr), 32'(tbl[i].first_addr));
        check($sformatf("v%0d_first_len", i), 32'(first_len), 32'(tbl[i].first_len));
        check($sformatf("v%0d_last_addr", i), 32'(last_addr), 32'(tbl[i].last_addr));
        check($sformatf("v%0d_last_len", i), 32'(last_len), 32'(tbl[i].last_len));
      end
    end

    // Backpressure: level above FIFO_DEPTH-BURST_LEN (448) holds the FSM in CHECK.
    h_disp = 11'd8; v_disp = 11'd20; frame_base = 24'h000800;
    fifo_level = 10'd460; ctrl_en = 1'b1; out_vsync = 1'b1; cnt = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 3) out_vsync = 1'b0;
      if (rd_req) cnt++;
    end
    check("bp_no_req_460", 32'(cnt), 0);
    check("bp_active", 32'(frame_active), 1);
    check("bp_flush_over", 32'(fifo_flush), 0);
    fifo_level = 10'd449; cnt = 0;
    repeat (3) begin tick(); if (rd_req) cnt++; end
    check("bp_no_req_449", 32'(cnt), 0);
    fifo_level = 10'd448;
    tick();
    check("bp_req_448", 32'(rd_req), 1);
    check("bp_addr", 32'(rd_addr), 32'h000800);
    check("bp_len", 32'(rd_len), 64);
    cnt = 0;
    repeat (3) begin tick(); if (rd_req) cnt++; end
    check("bp_req_held", 32'(cnt), 3);

    // Reset while the request is outstanding.
    sys_rst_n = 1'b0;
    tick();
    check_idle_outputs("rst_mid_req");
    sys_rst_n = 1'b1; fifo_level = 10'd0; cnt = 0;
    repeat (10) begin tick(); if (rd_req || frame_active) cnt++; end
    check("rst_no_restart", 32'(cnt), 0);

    // Vsync during the second burst's WAIT (remaining = 96).
    frame_base = 24'h000400; out_vsync = 1'b1;
    repeat (3) tick();
    out_vsync = 1'b0;
    wait_req(40, ok);
    check("mf_req1", 32'(ok), 1);
    rd_ack = 1'b1; tick(); rd_ack = 1'b0; rd_done = 1'b1; tick(); rd_done = 1'b0;
    wait_req(10, ok);
    check("mf_req2", 32'(ok), 1);
    check("mf_req2_addr", 32'(rd_addr), 32'h000440);
    nu = 0; nf = 0;
    rd_ack = 1'b1; out_vsync = 1'b1;
    tick(); rd_ack = 1'b0; if (underrun) nu++;
    tick(); if (underrun) nu++;
    check("mf_underrun_pulse", 32'(underrun), 1);
    rd_done = 1'b1;
    tick(); rd_done = 1'b0; out_vsync = 1'b0; if (underrun) nu++;
    for (int c = 0; c < 40 && !rd_req; c++) begin
      tick();
      if (underrun) nu++;
      if (fifo_flush) nf++;
    end
    check("mf_underrun_count", 32'(nu), 1);
    check("mf_reflush", 32'(nf), 4);
    check("mf_restart_req", 32'(rd_req), 1);
    check("mf_restart_addr", 32'(rd_addr), 32'h000400);
    check("mf_restart_len", 32'(rd_len), 64);
    sys_rst_n = 1'b0; tick(); sys_rst_n = 1'b1; tick();

`ifdef LCD_FETCH_DBLBUF_EN
    buf_sel = 1'b1; frame_base_b = 24'hABC000;
    run_frame(11'd8, 11'd1, 24'h000111);
    check("db_first_addr", 32'(first_addr), 32'hABC000);
    check("db_cur_buf", 32'(cur_buf), 1);
    check("db_nbursts", 32'(nb), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
